// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding AXI4-Lite initiator: one cmd in, one AXI-Lite read or write out, one rsp back.
// Latency: 3 edges from cmd accept to rsp_valid (zero-wait slave); backpressure: cmd_ready only in IDLE, rsp held until rsp_ready.
module axi_lite_master_bridge #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ADDR_WIDTH-1:0]     M_AXI_awaddr,
  output logic [2:0]                M_AXI_awprot,
  output logic                      M_AXI_awvalid,
  input  logic                      M_AXI_awready,
  output logic [DATA_WIDTH-1:0]     M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_wstrb,
  output logic                      M_AXI_wvalid,
  input  logic                      M_AXI_wready,
  input  logic [1:0]                M_AXI_bresp,
  input  logic                      M_AXI_bvalid,
  output logic                      M_AXI_bready,
  output logic [ADDR_WIDTH-1:0]     M_AXI_araddr,
  output logic [2:0]                M_AXI_arprot,
  output logic                      M_AXI_arvalid,
  input  logic                      M_AXI_arready,
  input  logic [DATA_WIDTH-1:0]     M_AXI_rdata,
  input  logic [1:0]                M_AXI_rresp,
  input  logic                      M_AXI_rvalid,
  input  logic                      M_AXI_rlast,
  output logic                      M_AXI_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RSP
  } state_t;

  state_t                    state_q, state_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      bready_q, bready_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;

  logic aw_hs, w_hs;

  // Single-beat AXI-Lite: rlast carries no information here.
  logic unused_rlast;
  assign unused_rlast = M_AXI_rlast;

  assign aw_hs = awvalid_q & M_AXI_awready;
  assign w_hs  = wvalid_q & M_AXI_wready;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end

      S_WR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // Both channels may complete in the same cycle, so look at this cycle's handshakes too.
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        if (bready_q & M_AXI_bvalid) begin
          rsp_resp_d  = M_AXI_bresp;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end

      S_RD_ADDR: begin
        if (arvalid_q & M_AXI_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        if (rready_q & M_AXI_rvalid) begin
          rsp_rdata_d = M_AXI_rdata;
          rsp_resp_d  = M_AXI_rresp;
          rsp_write_d = 1'b0;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign M_AXI_awaddr  = addr_q;
  assign M_AXI_awprot  = PROT;
  assign M_AXI_awvalid = awvalid_q;
  assign M_AXI_wdata   = wdata_q;
  assign M_AXI_wstrb   = wstrb_q;
  assign M_AXI_wvalid  = wvalid_q;
  assign M_AXI_bready  = bready_q;
  assign M_AXI_araddr  = addr_q;
  assign M_AXI_arprot  = PROT;
  assign M_AXI_arvalid = arvalid_q;
  assign M_AXI_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: delay-configurable AXI-Lite RAM slave plus a word-array reference model.
module tb_axi_lite_master_bridge;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 ACLK = ~ACLK;

  axi_lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT(3'b000)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_awaddr(awaddr), .M_AXI_awprot(awprot), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
    .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
    .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
    .M_AXI_araddr(araddr), .M_AXI_arprot(arprot), .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
    .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rvalid(rvalid), .M_AXI_rlast(1'b1),
    .M_AXI_rready(rready)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // ---------------- slave: RAM with per-channel ready/valid delays ----------------
  int         aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  int         aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  int         aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0;
  logic       aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
  logic       mem_cleared = 1'b0;
  logic [31:0] aw_a = '0, w_d = '0, ar_a = '0;
  logic [3:0]  w_s = '0;
  logic [31:0] mem [0:63];

  wire aw_hs = awvalid && awready;
  wire w_hs  = wvalid && wready;
  wire ar_hs = arvalid && arready;
  wire wr_commit = (aw_got || aw_hs) && (w_got || w_hs);
  wire [31:0] c_addr = aw_hs ? awaddr : aw_a;
  wire [31:0] c_data = w_hs ? wdata : w_d;
  wire [3:0]  c_strb = w_hs ? wstrb : w_s;

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign arready = arvalid && (ar_cnt >= ar_dly);
  assign bvalid  = b_pend && (b_cnt >= b_dly);
  assign bresp   = bvalid ? b_resp_cfg : 2'b00;
  assign rvalid  = r_pend && (r_cnt >= r_dly);
  assign rdata   = rvalid ? mem[ar_a[7:2]] : 32'h0;
  assign rresp   = rvalid ? r_resp_cfg : 2'b00;

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      if (!mem_cleared) begin
        for (int i = 0; i < 64; i++) mem[i] <= '0;
        mem_cleared <= 1'b1;
      end
    end else begin
      if (aw_hs) begin
        aw_cnt <= 0; aw_got <= 1'b1; aw_a <= awaddr; aw_hs_cnt <= aw_hs_cnt + 1;
      end else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin
        w_cnt <= 0; w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; w_hs_cnt <= w_hs_cnt + 1;
      end else if (wvalid) w_cnt <= w_cnt + 1;
      if (bvalid && bready) begin
        b_pend <= 1'b0; b_hs_cnt <= b_hs_cnt + 1;
      end else if (b_pend) b_cnt <= b_cnt + 1;
      if (wr_commit) begin
        for (int i = 0; i < 4; i++)
          if (c_strb[i]) mem[c_addr[7:2]][8*i +: 8] <= c_data[8*i +: 8];
        b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (rvalid && rready) r_pend <= 1'b0;
      else if (r_pend) r_cnt <= r_cnt + 1;
      if (ar_hs) begin
        ar_cnt <= 0; ar_a <= araddr; r_pend <= 1'b1; r_cnt <= 0; ar_hs_cnt <= ar_hs_cnt + 1;
      end else if (arvalid) ar_cnt <= ar_cnt + 1;
    end
  end

  // ---------------- protocol monitor ----------------
  logic        p_rst = 1'b1, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
  logic [3:0]  p_wstrb = '0;

  always @(negedge ACLK) begin
    if (!ARESET && !p_rst) begin
      if (p_awv && !p_awr) check("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_wv && !p_wr)   check("w_hold", {wvalid, wdata, wstrb}, {1'b1, p_wdata, p_wstrb});
      if (p_arv && !p_arr) check("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
      if (bready)          check("bready_before_aw_w", b_pend, 1'b1);
    end
    p_rst = ARESET;
    p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
    p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
    p_arv = arvalid; p_arr = arready; p_araddr = araddr;
  end

  // ---------------- reference model: word array with byte-masked writes ----------------
  logic [31:0] ref_mem [0:63];

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++) if (s[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  // Both called just after a negedge; return just after a negedge.
  task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    check("cmd_ready_idle", cmd_ready, 1'b1);
    if (wr) ref_mem[a[7:2]] = (ref_mem[a[7:2]] & ~strb_mask(s)) | (d & strb_mask(s));
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input bit wr, input logic [31:0] want_d, input logic [1:0] want_r,
                         input int hold, input bit poke, output int lat);
    logic [34:0] snap;
    lat = 0;
    while (!rsp_valid && lat < 300) begin
      @(negedge ACLK);
      lat++;
    end
    check("rsp_valid_timeout", rsp_valid, 1'b1);
    check("rsp_write", rsp_write, wr);
    check("rsp_rdata", rsp_rdata, want_d);
    check("rsp_resp", rsp_resp, want_r);
    snap = {rsp_write, rsp_rdata, rsp_resp};
    if (poke) begin
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h3C; cmd_wdata = 32'h0BAD0BAD; cmd_wstrb = 4'hF;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      check("rsp_stable", {rsp_valid, cmd_ready, rsp_write, rsp_rdata, rsp_resp}, {1'b1, 1'b0, snap});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
    check("rsp_release", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int hold, input bit poke, output int lat);
    int aw0, w0, b0, ar0;
    logic [31:0] want_d;
    logic [1:0]  want_r;
    aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt; ar0 = ar_hs_cnt;
    want_d = wr ? 32'h0 : ref_mem[a[7:2]];
    want_r = wr ? b_resp_cfg : r_resp_cfg;
    send_cmd(wr, a, d, s);
    get_rsp(wr, want_d, want_r, hold, poke, lat);
    repeat (2) @(negedge ACLK);
    check("handshake_counts", {aw_hs_cnt - aw0, w_hs_cnt - w0, b_hs_cnt - b0, ar_hs_cnt - ar0},
          wr ? {32'd1, 32'd1, 32'd1, 32'd0} : {32'd0, 32'd0, 32'd0, 32'd1});
    check("no_extra_rsp", rsp_valid, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, n;
    bit wr;
    logic [31:0] a, d;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge ACLK);
    check("reset_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_addr", {awaddr, araddr}, 64'h0);
    check("reset_wdata", {wdata, wstrb}, 36'h0);
    check("reset_rsp", {rsp_rdata, rsp_resp, rsp_write}, 35'h0);
    check("prot", {awprot, arprot}, 6'b0);
    ARESET = 1'b0;
    @(negedge ACLK);

    // Zero-wait write then readback.
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, lat);
    check("wr_latency", lat, 2);
    check("aw_addr_seen", aw_a, 32'h10);
    check("w_data_seen", {w_d, w_s}, {32'hDEADBEEF, 4'hF});
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, lat);
    check("rd_latency", lat, 2);

    // W accepted 3 cycles before AW.
    aw_dly = 3;
    do_txn(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 1, 1'b0, lat);
    aw_dly = 0;
    do_txn(1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, lat);

    // AW accepted before W.
    w_dly = 2;
    do_txn(1'b1, 32'h34, 32'h01234567, 4'hF, 0, 1'b0, lat);
    w_dly = 0;

    // Partial write over a full word.
    do_txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, lat);
    do_txn(1'b1, 32'h20, 32'h0000AB00, 4'b0010, 0, 1'b0, lat);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, lat);
    check("partial_readback", rdata === 32'h0 ? ref_mem[8] : 32'hX, 32'h1122AB44);

    // Slow AR and R with SLVERR; DECERR on a write.
    ar_dly = 5; r_dly = 4; r_resp_cfg = 2'b10;
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, lat);
    check("slow_rd_latency", lat, 11);
    ar_dly = 0; r_dly = 0; r_resp_cfg = 2'b00;
    b_resp_cfg = 2'b11;
    do_txn(1'b1, 32'h24, 32'h55AA55AA, 4'hF, 0, 1'b0, lat);
    b_resp_cfg = 2'b00;

    // rsp_ready held low 6 cycles with a competing command present.
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 6, 1'b1, lat);
    check("poked_cmd_not_taken", {awvalid, wvalid, arvalid, cmd_ready}, 4'b0001);

    // Reset while waiting for B.
    b_dly = 20;
    send_cmd(1'b1, 32'h14, 32'h5A5A5A5A, 4'hF);
    n = 0;
    while (!bready && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    check("wr_resp_reached", bready, 1'b1);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("midreset_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
    check("midreset_cmd_ready", cmd_ready, 1'b1);
    ARESET = 1'b0;
    b_dly = 0;
    @(negedge ACLK);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, lat);
    check("post_reset_latency", lat, 2);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      b_resp_cfg = 2'($urandom_range(0, 3)); r_resp_cfg = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 15)) << 2;
      d  = $urandom;
      do_txn(wr, a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2), 1'b0, lat);
      if (wr) check("rand_wr_latency", lat, 2 + (aw_dly > w_dly ? aw_dly : w_dly) + b_dly);
      else    check("rand_rd_latency", lat, 2 + ar_dly + r_dly);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
